// File: rtl/wb_commit_checker_pkg.sv
// Shared definitions for the WB-stage commit checker: FSM encodings,
// default widths and the hard-wired zero register index.
package wb_commit_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } chk_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    // Register index that reads as zero; writes to it are architectural no-ops
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/wb_commit_checker_exp_fifo.sv
// Synchronous FIFO holding the expected (rd, data) commits in program order.
// Push and pop may happen in the same cycle; a push into a full FIFO is
// dropped even if a pop frees a slot on the same edge.
module wb_commit_checker_exp_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is data only and is never cleared; occupancy guards reads
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit_checker.sv
// In-order commit checker: compares every WB register write against the
// head of an expected-commit queue, counts commits and mismatches, runs a
// stall watchdog and settles into PASS or FAIL.
module wb_commit_checker
    import wb_commit_checker_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [REG_W-1:0]  exp_rd,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              end_of_test,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [1:0]        state,
    output logic [REG_W-1:0]  first_err_rd,
    output logic [DATA_W-1:0] first_err_data,
    output logic              timeout
);

    localparam int AW   = $clog2(DEPTH);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    chk_state_t          state_q;
    logic [WD_W-1:0]     wd_q;
    logic [WD_W-1:0]     wd_next;
    logic [REG_W+DATA_W-1:0] head;
    logic [REG_W-1:0]    head_rd;
    logic [DATA_W-1:0]   head_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         fifo_count;
    logic [AW+1:0]       occ_next;
    logic                push_acc;
    logic                commit;
    logic                pop;
    logic                mism;
    logic                wd_expire;

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    wb_commit_checker_exp_fifo #(
        .W     (REG_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push_acc),
        .pop   (pop),
        .wdata ({exp_rd, exp_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign exp_ready = !fifo_full;
    assign head_rd   = head[DATA_W +: REG_W];
    assign head_data = head[DATA_W-1:0];
    assign state     = state_q;

    assign push_acc  = exp_valid && !fifo_full;
    assign commit    = wb_regwrite && (wb_rd != REG_W'(REG_ZERO));
    assign pop       = commit && !fifo_empty;
    assign mism      = commit && (fifo_empty || (head_rd != wb_rd) || (head_data != wb_data));
    // Occupancy as it will be after this edge, so a final commit that
    // coincides with end_of_test is accounted for before judging PASS
    assign occ_next  = {1'b0, fifo_count} + (AW+2)'(push_acc) - (AW+2)'(pop);
    assign wd_next   = wd_q + 1'b1;
    assign wd_expire = (state_q == ST_RUN) && !commit && !fifo_empty
                       && (wd_next == WD_W'(TIMEOUT));

    // Checker FSM, counters, first-error capture and stall watchdog
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            commit_cnt     <= '0;
            mismatch_cnt   <= '0;
            first_err_rd   <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
            wd_q           <= '0;
        end else begin
            if (commit) commit_cnt <= sat_inc(commit_cnt);
            if (mism) begin
                mismatch_cnt <= sat_inc(mismatch_cnt);
                if (mismatch_cnt == '0) begin
                    first_err_rd   <= wb_rd;
                    first_err_data <= wb_data;
                end
            end

            if ((state_q != ST_RUN) || commit || fifo_empty) wd_q <= '0;
            else                                             wd_q <= wd_next;

            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (mism) begin
                        state_q <= ST_FAIL;
                    end else if (wd_expire) begin
                        state_q <= ST_FAIL;
                        timeout <= 1'b1;
                    end else if (end_of_test) begin
                        state_q <= ((occ_next == '0) && (mismatch_cnt == '0)) ? ST_PASS : ST_FAIL;
                    end else if ((state_q == ST_IDLE) && (push_acc || commit)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_PASS: if (mism) state_q <= ST_FAIL;
                default: state_q <= ST_FAIL;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_commit_checker.sv
// Directed bench for wb_commit_checker with hand-computed expectations.
`timescale 1ns/1ps
module tb_wb_commit_checker;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    logic              CLK;
    logic              RESET;
    logic              exp_valid;
    logic              exp_ready;
    logic [REG_W-1:0]  exp_rd;
    logic [DATA_W-1:0] exp_data;
    logic              wb_regwrite;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              end_of_test;
    logic [CNT_W-1:0]  commit_cnt;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [1:0]        state;
    logic [REG_W-1:0]  first_err_rd;
    logic [DATA_W-1:0] first_err_data;
    logic              timeout;

    int n_chk  = 0;
    int n_pass = 0;

    wb_commit_checker #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .DEPTH   (8),
        .TIMEOUT (64),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_rd         (exp_rd),
        .exp_data       (exp_data),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .end_of_test    (end_of_test),
        .commit_cnt     (commit_cnt),
        .mismatch_cnt   (mismatch_cnt),
        .state          (state),
        .first_err_rd   (first_err_rd),
        .first_err_data (first_err_data),
        .timeout        (timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        exp_valid = 0; exp_rd = 0; exp_data = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0; end_of_test = 0;
        RESET = 1;
        step();
        RESET = 0;
    endtask

    task automatic push(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
        exp_valid = 1; exp_rd = rd; exp_data = d;
        step();
        exp_valid = 0;
    endtask

    task automatic wb(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
        wb_regwrite = 1; wb_rd = rd; wb_data = d;
        step();
        wb_regwrite = 0;
    endtask

    task automatic eot();
        end_of_test = 1;
        step();
        end_of_test = 0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_ready", exp_ready, 1);
        check("rst_commit", commit_cnt, 0);
        check("rst_mism", mismatch_cnt, 0);
        check("rst_state", state, 2'b00);
        check("rst_err_rd", first_err_rd, 0);
        check("rst_err_data", first_err_data, 0);
        check("rst_timeout", timeout, 0);

        // Clean two-commit program ends in PASS
        push(8, 32'h5);
        push(9, 32'hA);
        check("t1_run", state, 2'b01);
        wb(8, 32'h5);
        wb(9, 32'hA);
        eot();
        check("t1_commit", commit_cnt, 2);
        check("t1_mism", mismatch_cnt, 0);
        check("t1_pass", state, 2'b10);
        // Late unexpected write turns PASS into FAIL
        wb(3, 32'h3);
        check("t1_pass_to_fail", state, 2'b11);
        check("t1_commit3", commit_cnt, 3);

        // Data mismatch latches first error; later ones do not overwrite it
        do_reset();
        push(8, 32'h5);
        wb(8, 32'h6);
        check("t2_mism", mismatch_cnt, 1);
        check("t2_err_rd", first_err_rd, 8);
        check("t2_err_data", first_err_data, 32'h6);
        check("t2_fail", state, 2'b11);
        wb(9, 32'h7);
        check("t2_mism2", mismatch_cnt, 2);
        check("t2_err_rd_kept", first_err_rd, 8);
        check("t2_err_data_kept", first_err_data, 32'h6);
        check("t2_commit2", commit_cnt, 2);

        // Full queue: 9th offer held across a pop, accepted one cycle later
        do_reset();
        for (int i = 0; i < 8; i++) push(REG_W'(i + 1), 32'h100 + i);
        check("t3_full", exp_ready, 0);
        exp_valid = 1; exp_rd = 10; exp_data = 32'h200;
        step();
        check("t3_still_full", exp_ready, 0);
        wb_regwrite = 1; wb_rd = 1; wb_data = 32'h100;
        step();
        wb_regwrite = 0;
        check("t3_ready_after_pop", exp_ready, 1);
        check("t3_commit1", commit_cnt, 1);
        step();
        exp_valid = 0;
        check("t3_refull", exp_ready, 0);
        for (int i = 1; i < 8; i++) wb(REG_W'(i + 1), 32'h100 + i);
        wb(10, 32'h200);
        eot();
        check("t3_commit9", commit_cnt, 9);
        check("t3_mism0", mismatch_cnt, 0);
        check("t3_pass", state, 2'b10);

        // Watchdog expires exactly on the 64th stalled cycle
        do_reset();
        push(3, 32'h1);
        for (int i = 0; i < 63; i++) step();
        check("t4_no_to_63", timeout, 0);
        check("t4_run_63", state, 2'b01);
        step();
        check("t4_timeout", timeout, 1);
        check("t4_to_fail", state, 2'b11);

        // Commit on cycle 63 keeps the watchdog quiet
        do_reset();
        push(3, 32'h1);
        for (int i = 0; i < 62; i++) step();
        wb(3, 32'h1);
        check("t4b_no_to", timeout, 0);
        for (int i = 0; i < 80; i++) step();
        check("t4b_no_to_late", timeout, 0);
        check("t4b_run", state, 2'b01);
        check("t4b_mism", mismatch_cnt, 0);

        // $zero writes ignored; unexpected write on empty queue fails
        do_reset();
        wb(0, 32'hFFFF);
        check("t5_r0_commit", commit_cnt, 0);
        check("t5_r0_mism", mismatch_cnt, 0);
        check("t5_r0_idle", state, 2'b00);
        wb(4, 32'h44);
        check("t5_commit", commit_cnt, 1);
        check("t5_mism", mismatch_cnt, 1);
        check("t5_err_rd", first_err_rd, 4);
        check("t5_fail", state, 2'b11);

        // Asynchronous reset mid-run clears everything without a clock edge
        do_reset();
        for (int i = 0; i < 4; i++) push(REG_W'(i + 1), 32'h10 + i);
        wb(1, 32'h10);
        check("t6_pre_commit", commit_cnt, 1);
        #2;
        RESET = 1;
        #1;
        check("t6_async_commit", commit_cnt, 0);
        check("t6_async_state", state, 2'b00);
        check("t6_async_ready", exp_ready, 1);
        @(negedge CLK);
        RESET = 0;
        #1;
        wb(7, 32'h7);
        check("t6_empty_mism", mismatch_cnt, 1);

        // end_of_test together with the final matching commit
        do_reset();
        push(5, 32'h55);
        wb_regwrite = 1; wb_rd = 5; wb_data = 32'h55; end_of_test = 1;
        step();
        wb_regwrite = 0; end_of_test = 0;
        check("t7_coinc_pass", state, 2'b10);

        // end_of_test with an entry still pending
        do_reset();
        push(5, 32'h1);
        push(6, 32'h2);
        wb(5, 32'h1);
        eot();
        check("t8_pending_fail", state, 2'b11);
        check("t8_mism", mismatch_cnt, 0);

        // Empty program passes straight from IDLE
        do_reset();
        eot();
        check("t9_empty_pass", state, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
